// File: rtl/fetch_issue_unit_pkg.sv
// Shared definitions for the fetch issue unit.
//   - PC_select encodings (sequential, branch, JAL, JALR)
//   - NOP bubble encoding (addi x0, x0, 0)
//   - fetch FSM state enum
package fetch_issue_unit_pkg;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JAL    = 2'b10;
   localparam logic [1:0] PC_JALR   = 2'b11;

   // Default NOP_INSTR value used for bubbles.
   localparam logic [31:0] NOP_INSTR_WORD = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/fetch_issue_unit_skid_buffer.sv
// fetch_skid_buffer: one-entry instruction/PC holding register that catches a
// memory response arriving while decode is stalled and the output is full.
// Ports:
//   clock, reset        clock and synchronous active-high reset (clears valid)
//   load                capture load_data/load_pc (wins over unload)
//   unload              entry consumed this cycle
//   clear               flush on redirect (highest priority)
//   load_data, load_pc  entry to capture
//   valid, data, pc     current entry
module fetch_skid_buffer
   import fetch_issue_unit_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    unload,
   input  logic                    clear,
   input  logic [DATA_WIDTH-1:0]   load_data,
   input  logic [ADDRESS_BITS-1:0] load_pc,
   output logic                    valid,
   output logic [DATA_WIDTH-1:0]   data,
   output logic [ADDRESS_BITS-1:0] pc
);

   // Only the valid flag is reset; the payload is qualified by it.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (load && !clear) begin
         data <= load_data;
         pc   <= load_pc;
      end
   end

endmodule

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: fetch front end. Owns the PC, issues one instruction-memory
// read at a time, and drives the instruction/PC pair captured by the
// fetch-to-decode register. Redirects flush in-flight state; stale responses
// are dropped. A NOP bubble is presented whenever no valid instruction exists.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf_fetched and
// perf_discarded counters.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   start, program_address       begin fetching at program_address (IDLE only)
//   stall                        decode not accepting; output register holds
//   PC_select, *_target          next-PC source and redirect targets
//   imem_req_valid/ready/address instruction-memory request channel
//   imem_resp_valid/data         instruction-memory response (in order)
//   instruction_fetch, inst_PC_fetch, fetch_valid   output to decode register
module fetch_issue_unit
   import fetch_issue_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDRESS_BITS = 20,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = NOP_INSTR_WORD
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_BITS-1:0] program_address,
   input  logic                    stall,
   input  logic [1:0]              PC_select,
   input  logic [ADDRESS_BITS-1:0] branch_target,
   input  logic [ADDRESS_BITS-1:0] JAL_target,
   input  logic [ADDRESS_BITS-1:0] JALR_target,
   output logic                    imem_req_valid,
   input  logic                    imem_req_ready,
   output logic [ADDRESS_BITS-1:0] imem_address,
   input  logic                    imem_resp_valid,
   input  logic [DATA_WIDTH-1:0]   imem_resp_data,
   output logic [DATA_WIDTH-1:0]   instruction_fetch,
   output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]             perf_fetched,
   output logic [31:0]             perf_discarded,
`endif
   output logic                    fetch_valid
);

   fetch_state_e            state;
   logic [ADDRESS_BITS-1:0] pc;
   logic [ADDRESS_BITS-1:0] req_pc;
   logic                    discard;

   logic [ADDRESS_BITS-1:0] redirect_target;
   logic                    redirect;
   logic                    accepted;
   logic                    resp_seen;
   logic                    deliver;
   logic                    drop;

   logic                    skid_valid;
   logic [DATA_WIDTH-1:0]   skid_data;
   logic [ADDRESS_BITS-1:0] skid_pc;
   logic                    skid_load;
   logic                    skid_unload;

   always_comb begin
      redirect_target = pc;
      case (PC_select)
         PC_BRANCH: redirect_target = branch_target;
         PC_JAL:    redirect_target = JAL_target;
         PC_JALR:   redirect_target = JALR_target & ~ADDRESS_BITS'(1);
         default:   redirect_target = pc;
      endcase
   end

   // Redirects only matter once fetching has begun; in IDLE start has the say.
   assign redirect       = (state != IDLE) && (PC_select != PC_SEQ);
   // A full skid buffer blocks new requests so a response always has a home.
   assign imem_req_valid = (state == ISSUE) && !skid_valid;
   assign imem_address   = pc;
   assign accepted       = imem_req_valid && imem_req_ready;
   assign resp_seen      = (state == WAIT) && imem_resp_valid;
   assign deliver        = resp_seen && !discard && !redirect;
   assign drop           = resp_seen && (discard || redirect);

   assign skid_unload = !stall && skid_valid;
   assign skid_load   = deliver && ((stall && fetch_valid) || (!stall && skid_valid));

   fetch_skid_buffer #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_BITS (ADDRESS_BITS)
   ) u_skid (
      .clock     (clock),
      .reset     (reset),
      .load      (skid_load),
      .unload    (skid_unload),
      .clear     (redirect),
      .load_data (imem_resp_data),
      .load_pc   (req_pc),
      .valid     (skid_valid),
      .data      (skid_data),
      .pc        (skid_pc)
   );

   // Fetch FSM: PC, outstanding-request tracking and stale-response discard.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= '0;
         discard <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pc    <= program_address;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (redirect) begin
                  pc <= redirect_target;
                  if (accepted) begin
                     // The request just sent targets the old path.
                     discard <= 1'b1;
                     state   <= WAIT;
                  end
               end else if (accepted) begin
                  req_pc <= pc;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (redirect) begin
                  pc <= redirect_target;
                  if (imem_resp_valid) begin
                     // Response consumed and dropped right now; nothing left in flight.
                     discard <= 1'b0;
                     state   <= ISSUE;
                  end else begin
                     discard <= 1'b1;
                  end
               end else if (imem_resp_valid) begin
                  if (!discard) begin
                     pc <= req_pc + ADDRESS_BITS'(4);
                  end
                  discard <= 1'b0;
                  state   <= ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register toward decode; skid entry is older than a new delivery.
   always_ff @(posedge clock) begin
      if (reset) begin
         instruction_fetch <= NOP_INSTR;
         inst_PC_fetch     <= '0;
         fetch_valid       <= 1'b0;
      end else if (redirect) begin
         instruction_fetch <= NOP_INSTR;
         fetch_valid       <= 1'b0;
      end else if (!stall) begin
         if (skid_valid) begin
            instruction_fetch <= skid_data;
            inst_PC_fetch     <= skid_pc;
            fetch_valid       <= 1'b1;
         end else if (deliver) begin
            instruction_fetch <= imem_resp_data;
            inst_PC_fetch     <= req_pc;
            fetch_valid       <= 1'b1;
         end else begin
            instruction_fetch <= NOP_INSTR;
            fetch_valid       <= 1'b0;
         end
      end else if (!fetch_valid && deliver) begin
         // Stalled on a bubble: the bubble may be overwritten.
         instruction_fetch <= imem_resp_data;
         inst_PC_fetch     <= req_pc;
         fetch_valid       <= 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched   <= '0;
         perf_discarded <= '0;
      end else begin
         if (deliver && (perf_fetched != 32'hFFFF_FFFF)) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (drop && (perf_discarded != 32'hFFFF_FFFF)) begin
            perf_discarded <= perf_discarded + 32'd1;
         end
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed, table-driven bench for fetch_issue_unit. Memory model returns the
// zero-extended request address as instruction data, with 1 or 2 cycle latency.
module tb_fetch_issue_unit;

   localparam int DW = 32;
   localparam int AB = 20;
   localparam logic [31:0] NOP = 32'h00000013;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AB-1:0] program_address;
   logic          stall;
   logic [1:0]    PC_select;
   logic [AB-1:0] branch_target;
   logic [AB-1:0] JAL_target;
   logic [AB-1:0] JALR_target;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AB-1:0] imem_address;
   logic          imem_resp_valid = 1'b0;
   logic [DW-1:0] imem_resp_data  = '0;
   logic [DW-1:0] instruction_fetch;
   logic [AB-1:0] inst_PC_fetch;
   logic          fetch_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]   perf_fetched;
   logic [31:0]   perf_discarded;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   fetch_issue_unit dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .program_address   (program_address),
      .stall             (stall),
      .PC_select         (PC_select),
      .branch_target     (branch_target),
      .JAL_target        (JAL_target),
      .JALR_target       (JALR_target),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_address      (imem_address),
      .imem_resp_valid   (imem_resp_valid),
      .imem_resp_data    (imem_resp_data),
      .instruction_fetch (instruction_fetch),
      .inst_PC_fetch     (inst_PC_fetch),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched      (perf_fetched),
      .perf_discarded    (perf_discarded),
`endif
      .fetch_valid       (fetch_valid)
   );

   // Instruction memory model; ignores reset so stale responses can arrive.
   logic          slow = 1'b0;
   logic          pend_v = 1'b0;
   logic [DW-1:0] pend_d = '0;
   always @(posedge clock) begin
      pend_v <= imem_req_valid && imem_req_ready;
      pend_d <= DW'(imem_address);
      if (slow) begin
         imem_resp_valid <= pend_v;
         imem_resp_data  <= pend_d;
      end else begin
         imem_resp_valid <= imem_req_valid && imem_req_ready;
         imem_resp_data  <= DW'(imem_address);
      end
   end

   typedef struct {
      logic          rst;
      logic          st;
      logic [AB-1:0] pa;
      logic          stl;
      logic          rdy;
      logic [1:0]    sel;
      logic [AB-1:0] tgt;
      logic          e_fv;
      logic [AB-1:0] e_pc;
      logic          e_rv;
      logic [AB-1:0] e_addr;
   } vec_t;

   function automatic vec_t mk(input int rst, input int st, input int pa, input int stl,
                               input int rdy, input int sel, input int tgt, input int efv,
                               input int epc, input int erv, input int eaddr);
      vec_t v;
      v.rst = 1'(rst);   v.st  = 1'(st);   v.pa   = AB'(pa);  v.stl    = 1'(stl);
      v.rdy = 1'(rdy);   v.sel = 2'(sel);  v.tgt  = AB'(tgt); v.e_fv   = 1'(efv);
      v.e_pc = AB'(epc); v.e_rv = 1'(erv); v.e_addr = AB'(eaddr);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clock);
      reset           = v.rst;
      start           = v.st;
      program_address = v.pa;
      stall           = v.stl;
      imem_req_ready  = v.rdy;
      PC_select       = v.sel;
      branch_target   = (v.sel == 2'b01) ? v.tgt : AB'('h0A5A0);
      JAL_target      = (v.sel == 2'b10) ? v.tgt : AB'('h05A50);
      JALR_target     = (v.sel == 2'b11) ? v.tgt : AB'('h0F0F1);
      @(posedge clock);
      #1;
      chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(v.e_fv));
      chk({tag, ".instr"}, instruction_fetch, v.e_fv ? {12'h0, v.e_pc} : NOP);
      if (v.e_fv) chk({tag, ".inst_pc"}, 32'(inst_PC_fetch), 32'(v.e_pc));
      chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(v.e_rv));
      if (v.e_rv || v.rst) chk({tag, ".req_addr"}, 32'(imem_address), 32'(v.e_addr));
   endtask

   vec_t tbl[28];

   initial begin
      reset = 1'b1; start = 1'b0; program_address = '0; stall = 1'b0;
      PC_select = 2'b00; branch_target = '0; JAL_target = '0; JALR_target = '0;
      imem_req_ready = 1'b1;

      //          rst st pa        stl rdy sel tgt      fv pc       rv addr
      // Test 1: start at 0x100, one instruction every 2 cycles
      tbl[0]  = mk(0, 1, 'h100,    0,  1,  0,  0,       0, 0,       1, 'h100);
      tbl[1]  = mk(0, 0, 0,        0,  1,  0,  0,       0, 0,       0, 0);
      tbl[2]  = mk(0, 0, 0,        0,  1,  0,  0,       1, 'h100,   1, 'h104);
      tbl[3]  = mk(0, 0, 0,        0,  1,  0,  0,       0, 0,       0, 0);
      tbl[4]  = mk(0, 0, 0,        0,  1,  0,  0,       1, 'h104,   1, 'h108);
      // Test 2: stall 6 cycles; 0x108 goes to the skid buffer, no new request
      tbl[5]  = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h104,   0, 0);
      tbl[6]  = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h104,   0, 0);
      tbl[7]  = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h104,   0, 0);
      tbl[8]  = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h104,   0, 0);
      tbl[9]  = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h104,   0, 0);
      tbl[10] = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h104,   0, 0);
      tbl[11] = mk(0, 0, 0,        0,  1,  0,  0,       1, 'h108,   1, 'h10C);
      tbl[12] = mk(0, 0, 0,        0,  1,  0,  0,       0, 0,       0, 0);
      tbl[13] = mk(0, 0, 0,        0,  1,  0,  0,       1, 'h10C,   1, 'h110);
      // Test 3: branch to 0x200 as 0x110 is accepted; 0x110 response dropped
      tbl[14] = mk(0, 0, 0,        0,  1,  1,  'h200,   0, 0,       0, 0);
      tbl[15] = mk(0, 0, 0,        0,  1,  0,  0,       0, 0,       1, 'h200);
      tbl[16] = mk(0, 0, 0,        0,  1,  0,  0,       0, 0,       0, 0);
      tbl[17] = mk(0, 0, 0,        0,  1,  0,  0,       1, 'h200,   1, 'h204);
      // Test 4: fill skid with 0x204 under stall, then JALR 0x301 flushes it
      tbl[18] = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h200,   0, 0);
      tbl[19] = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h200,   0, 0);
      tbl[20] = mk(0, 0, 0,        1,  1,  3,  'h301,   0, 0,       1, 'h300);
      tbl[21] = mk(0, 0, 0,        1,  1,  0,  0,       0, 0,       0, 0);
      tbl[22] = mk(0, 0, 0,        1,  1,  0,  0,       1, 'h300,   1, 'h304);
      tbl[23] = mk(0, 0, 0,        0,  1,  0,  0,       0, 0,       0, 0);
      // JAL while a request waits for ready: stays in ISSUE at the new PC
      tbl[24] = mk(0, 0, 0,        0,  0,  0,  0,       1, 'h304,   1, 'h308);
      tbl[25] = mk(0, 0, 0,        0,  0,  2,  'h480,   0, 0,       1, 'h480);
      tbl[26] = mk(0, 0, 0,        0,  1,  0,  0,       0, 0,       0, 0);
      tbl[27] = mk(0, 0, 0,        0,  1,  0,  0,       1, 'h480,   1, 'h484);

      apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "reset_a");
      apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "reset_b");
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched_reset", perf_fetched, 32'd0);
      chk("perf_discarded_reset", perf_discarded, 32'd0);
`endif

      for (int i = 0; i < 28; i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched_table", perf_fetched, 32'd9);
      chk("perf_discarded_table", perf_discarded, 32'd1);
`endif

      // Test 5: PC wraps from 0xFFFFC to 0
      apply(mk(1, 0, 0,        0, 1, 0, 0, 0, 0,        0, 0),         "wrap.reset");
      apply(mk(0, 1, 'hFFFFC,  0, 1, 0, 0, 0, 0,        1, 'hFFFFC),   "wrap.start");
      apply(mk(0, 0, 0,        0, 1, 0, 0, 0, 0,        0, 0),         "wrap.acc0");
      apply(mk(0, 0, 0,        0, 1, 0, 0, 1, 'hFFFFC,  1, 'h00000),   "wrap.del0");
      apply(mk(0, 0, 0,        0, 1, 0, 0, 0, 0,        0, 0),         "wrap.acc1");
      apply(mk(0, 0, 0,        0, 1, 0, 0, 1, 'h00000,  1, 'h00004),   "wrap.del1");

      // Test 6: reset while waiting on a slow memory; stale response ignored
      slow = 1'b1;
      apply(mk(0, 0, 0,        0, 1, 0, 0, 0, 0,        0, 0),         "rstwait.acc");
      apply(mk(1, 0, 0,        0, 1, 0, 0, 0, 0,        0, 0),         "rstwait.reset");
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched_rst2", perf_fetched, 32'd0);
      chk("perf_discarded_rst2", perf_discarded, 32'd0);
`endif
      apply(mk(0, 1, 'h40,     0, 1, 0, 0, 0, 0,        1, 'h40),      "rstwait.start");
      apply(mk(0, 0, 0,        0, 1, 0, 0, 0, 0,        0, 0),         "rstwait.acc40");
      apply(mk(0, 0, 0,        0, 1, 0, 0, 0, 0,        0, 0),         "rstwait.lat");
      apply(mk(0, 0, 0,        0, 1, 0, 0, 1, 'h40,     1, 'h44),      "rstwait.del40");
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched_end", perf_fetched, 32'd1);
      chk("perf_discarded_end", perf_discarded, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Front end of the fetch stage: owns the PC, issues instruction-memory reads, and produces the instruction/PC pair that the fetch-to-decode pipeline register captures every cycle.
- Supports four PC sources (sequential, branch, JAL, JALR) and back-pressure via stall.
- Drops stale memory responses after a redirect.
- Presents a NOP bubble (32'h00000013) whenever it has no valid instruction.

Parameters:
DATA_WIDTH, 32, instruction width
ADDRESS_BITS, 20, PC/address width; PC arithmetic wraps modulo 2^ADDRESS_BITS
NOP_INSTR, 32'h00000013, bubble encoding driven when fetch_valid=0

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; loads program_address and begins fetching
program_address  input  ADDRESS_BITS  initial PC captured on start
stall  input  1  decode not accepting; output register holds
PC_select  input  2  00 PC+4, 01 branch_target, 10 JAL_target, 11 JALR_target
branch_target  input  ADDRESS_BITS  redirect target for PC_select=01
JAL_target  input  ADDRESS_BITS  redirect target for PC_select=10
JALR_target  input  ADDRESS_BITS  redirect target for PC_select=11; bit 0 forced to 0
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request
imem_address  output  ADDRESS_BITS  read address (= PC)
imem_resp_valid  input  1  read data valid; in-order, at most one outstanding
imem_resp_data  input  DATA_WIDTH  read data
instruction_fetch  output  DATA_WIDTH  instruction to fetch pipe register
inst_PC_fetch  output  ADDRESS_BITS  PC of instruction_fetch
fetch_valid  output  1  instruction_fetch is a real fetched instruction

Behaviour:
- Reset values:
  - state=IDLE, PC=0, discard=0, skid buffer empty.
  - imem_req_valid=0, imem_address=0.
  - instruction_fetch=NOP_INSTR, inst_PC_fetch=0, fetch_valid=0.
  - Reset mid-transaction abandons any outstanding request; a later response is ignored because state=IDLE.
- States: IDLE, ISSUE, WAIT.
  - IDLE: no requests. start -> PC<=program_address, go to ISSUE next cycle.
  - ISSUE: imem_req_valid=1, imem_address=PC. Requires the skid buffer to be empty; otherwise imem_req_valid=0 and state stays ISSUE. On req_ready, latch req_PC<=PC and go to WAIT.
  - WAIT: imem_req_valid=0. On resp_valid:
    - discard=1: drop data, clear discard, go to ISSUE.
    - Otherwise: deliver {resp_data, req_PC}, PC<=req_PC+4, go to ISSUE.
- Delivery:
  - Output register loads a delivered instruction if fetch_valid=0 or stall=0. Otherwise the instruction goes to the one-entry skid buffer.
  - When stall=0 and the buffer is full, the buffer moves to the output register that cycle; a new delivery then goes into the buffer.
  - stall=0 with nothing to deliver: output becomes NOP_INSTR with fetch_valid=0.
  - Best-case throughput: one instruction per 2 cycles with a zero-wait-state memory (one outstanding request).
- Redirect (PC_select!=00), evaluated every cycle, overrides stall:
  - PC<=selected target. Skid buffer cleared. Output register <= NOP_INSTR, fetch_valid=0.
  - In WAIT, or in ISSUE with req_ready the same cycle: discard<=1 and state=WAIT.
  - In ISSUE without acceptance: state stays ISSUE with the new PC on the next cycle.
  - A resp_valid arriving in the redirect cycle itself is dropped, and discard is not set.
  - Redirect in IDLE is ignored.
- Simultaneous start and redirect: start wins.
- start outside IDLE is ignored.
- PC+4 at 2^ADDRESS_BITS-4 wraps to 0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_discarded[31:0].
  - perf_fetched counts responses delivered to the output or buffer.
  - perf_discarded counts responses dropped due to discard or a same-cycle redirect.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package holds:
  - PC_select encodings: PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JAL=2'b10, PC_JALR=2'b11.
  - The NOP_INSTR constant.
  - The fetch state enum {IDLE, ISSUE, WAIT}.
- One sub-module, fetch_skid_buffer: one-entry data+PC holding register with load/unload/clear.

Test Plan:
1. Reset, start with program_address=0x100, zero-wait memory returning data=addr -> outputs PC 0x100, 0x104, 0x108 with fetch_valid=1, one instruction every 2 cycles; fetch_valid=0 before the first delivery.
2. stall held 6 cycles after PC 0x104 is presented -> output holds 0x104; 0x108 is captured in the skid buffer; no request issued; after release, 0x108 then 0x10C.
3. PC_select=01, branch_target=0x200, while a request to 0x110 is outstanding -> the 0x110 response is dropped; next valid output is PC 0x200; NOP bubble in between.
4. PC_select=11, JALR_target=0x301, during stall -> redirect honoured; next fetch address is 0x300; skid buffer contents flushed.
5. start with program_address=0xFFFFC (ADDRESS_BITS=20) -> PCs 0xFFFFC then 0x00000.
6. reset asserted while in WAIT, then start with program_address=0x40 -> the stale response is ignored; first valid output is PC 0x40. With FETCH_PERF_CNT_EN defined, perf counters read 0 after reset.
